// File: rtl/ex_writeback_stage.sv
// Writeback stage behind the ALU: holds the ALU outputs and the architectural flag register.
// It drives the register-file write port, with two write cycles for MUL/DIV, plus the forwarding bus and the retire counter.
module ex_writeback_stage #(
  parameter int DATA_W        = 16,
  parameter int REG_AW        = 3,
  parameter bit DUAL_WRITE_EN = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        opcode,
  input  logic [REG_AW-1:0] rd,
  input  logic              alu_en_out,
  input  logic [DATA_W-1:0] result_0,
  input  logic [DATA_W-1:0] result_1,
  input  logic [DATA_W-1:0] next_flags,
  output logic [DATA_W-1:0] current_flags,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retired_count,
  output logic [1:0]        state_dbg
);

  // Opcode encoding shared with the ALU decoder
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_CMP  = 5'd10;
  localparam logic [4:0] OP_SETF = 5'd11;
  localparam logic [4:0] OP_CLRF = 5'd12;
  localparam logic [4:0] OP_CPLF = 5'd13;
  localparam logic [4:0] OP_MOV  = 5'd16;
  localparam logic [4:0] OP_LBL  = 5'd17;
  localparam logic [4:0] OP_LBH  = 5'd18;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR0  = 2'd1,
    S_WR1  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                writes_rd_q;
  logic                dual_q;
  logic [REG_AW-1:0]   rd_q;
  logic [DATA_W-1:0]   res0_q;
  logic [DATA_W-1:0]   res1_q;
  logic [DATA_W-1:0]   flags_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                accept;
  logic                writes_rd_in;
  logic                dual_in;
  logic [REG_AW-1:0]   rd_inc;

  // Handshake: a transfer happens on a rising edge where in_valid && in_ready.
  // in_ready depends only on registered state, and upstream holds its inputs while in_ready=0.
  assign in_ready = !(state_q == S_WR0 && dual_q);
  assign accept   = in_valid && in_ready;

  always_comb begin
    writes_rd_in = 1'b0;
    if (alu_en_out) begin
      writes_rd_in = !(opcode == OP_CMP || opcode == OP_SETF ||
                       opcode == OP_CLRF || opcode == OP_CPLF);
    end else begin
      writes_rd_in = (opcode == OP_LBL || opcode == OP_LBH || opcode == OP_MOV);
    end
  end

  assign dual_in = DUAL_WRITE_EN && alu_en_out && (opcode == OP_MUL || opcode == OP_DIV);
  assign rd_inc  = rd_q + 1'b1;

  // State and capture registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      writes_rd_q <= 1'b0;
      dual_q      <= 1'b0;
      rd_q        <= '0;
      res0_q      <= '0;
      res1_q      <= '0;
      flags_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        writes_rd_q <= writes_rd_in;
        dual_q      <= dual_in;
        rd_q        <= rd;
        res0_q      <= result_0;
        res1_q      <= result_1;
        cnt_q       <= cnt_q + 1'b1;
        if (alu_en_out) flags_q <= next_flags;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = S_WR0;
    end else begin
      case (state_q)
        S_WR0:   state_d = dual_q ? S_WR1 : S_IDLE;
        S_WR1:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from registered state only
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (state_q)
      S_WR0: begin
        rf_we    = writes_rd_q;
        rf_waddr = rd_q;
        rf_wdata = res0_q;
      end
      S_WR1: begin
        rf_we    = 1'b1;
        rf_waddr = rd_inc;
        rf_wdata = res1_q;
      end
      default: ;
    endcase
  end

  assign fwd_valid     = rf_we;
  assign fwd_rd        = rf_waddr;
  assign fwd_data      = rf_wdata;
  assign current_flags = flags_q;
  assign retired_count = cnt_q;
  assign state_dbg     = state_q;

  // Tie-off for opcodes that are named for readability but never decoded here.
  logic unused_ops;
  assign unused_ops = ^{OP_ADD, OP_SUB};

endmodule

// File: tb/tb_ex_writeback_stage.sv
// Directed bench for ex_writeback_stage: one DUT with dual writes enabled, one with them disabled.
module tb_ex_writeback_stage;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_MUL = 5'd2;
  localparam logic [4:0] OP_DIV = 5'd3;
  localparam logic [4:0] OP_CMP = 5'd10;
  localparam logic [4:0] OP_MOV = 5'd16;
  localparam logic [4:0] OP_LBH = 5'd18;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [4:0]  opcode;
  logic [2:0]  rd;
  logic        alu_en_out;
  logic [15:0] result_0, result_1, next_flags;

  logic        in_ready,  rf_we,  fwd_valid;
  logic [2:0]  rf_waddr,  fwd_rd;
  logic [15:0] rf_wdata,  fwd_data, current_flags, retired_count;
  logic [1:0]  state_dbg;

  logic        in_ready2, rf_we2, fwd_valid2;
  logic [2:0]  rf_waddr2, fwd_rd2;
  logic [15:0] rf_wdata2, fwd_data2, current_flags2, retired_count2;
  logic [1:0]  state_dbg2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_writeback_stage #(.DUAL_WRITE_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .alu_en_out(alu_en_out),
    .result_0(result_0), .result_1(result_1), .next_flags(next_flags),
    .current_flags(current_flags), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .retired_count(retired_count), .state_dbg(state_dbg)
  );

  ex_writeback_stage #(.DUAL_WRITE_EN(1'b0)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .opcode(opcode), .rd(rd), .alu_en_out(alu_en_out),
    .result_0(result_0), .result_1(result_1), .next_flags(next_flags),
    .current_flags(current_flags2), .rf_we(rf_we2), .rf_waddr(rf_waddr2),
    .rf_wdata(rf_wdata2), .fwd_valid(fwd_valid2), .fwd_rd(fwd_rd2),
    .fwd_data(fwd_data2), .retired_count(retired_count2), .state_dbg(state_dbg2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write port plus forwarding bus, which must mirror it
  task automatic chk_wr(input string tag, input logic we, input logic [2:0] a, input logic [15:0] d);
    chk({tag, "_we"}, {31'd0, rf_we}, {31'd0, we});
    chk({tag, "_fwd_valid"}, {31'd0, fwd_valid}, {31'd0, we});
    if (we) begin
      chk({tag, "_waddr"}, {29'd0, rf_waddr}, {29'd0, a});
      chk({tag, "_wdata"}, {16'd0, rf_wdata}, {16'd0, d});
      chk({tag, "_fwd_rd"}, {29'd0, fwd_rd}, {29'd0, a});
      chk({tag, "_fwd_data"}, {16'd0, fwd_data}, {16'd0, d});
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [2:0] r, input logic alu,
                       input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] nf);
    in_valid = v; opcode = op; rd = r; alu_en_out = alu;
    result_0 = r0; result_1 = r1; next_flags = nf;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, OP_ADD, 3'd0, 1'b1, 16'h0, 16'h0, 16'h0);
    tick(); tick();
    reset = 1'b0;

    // Reset values
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_waddr", {29'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", {16'd0, rf_wdata}, 32'd0);
    chk("rst_flags", {16'd0, current_flags}, 32'd0);
    chk("rst_count", {16'd0, retired_count}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    // ADD r2
    drive(1'b1, OP_ADD, 3'd2, 1'b1, 16'h1234, 16'h0, 16'h0081);
    tick();
    in_valid = 1'b0;
    chk_wr("add", 1'b1, 3'd2, 16'h1234);
    chk("add_flags", {16'd0, current_flags}, 32'h0081);
    chk("add_count", {16'd0, retired_count}, 32'd1);
    tick();
    chk_wr("add_idle", 1'b0, 3'd0, 16'h0);

    // MUL r3 followed by a held MOV r5
    drive(1'b1, OP_MUL, 3'd3, 1'b1, 16'h5678, 16'h0009, 16'h0002);
    tick();
    drive(1'b1, OP_MOV, 3'd5, 1'b0, 16'hBEEF, 16'h0, 16'hFFFF);
    chk_wr("mul_lo", 1'b1, 3'd3, 16'h5678);
    chk("mul_lo_ready", {31'd0, in_ready}, 32'd0);
    chk("mul_flags", {16'd0, current_flags}, 32'h0002);
    chk("mul_count", {16'd0, retired_count}, 32'd2);
    tick();
    chk_wr("mul_hi", 1'b1, 3'd4, 16'h0009);
    chk("mul_hi_ready", {31'd0, in_ready}, 32'd1);
    chk("mul_hi_count", {16'd0, retired_count}, 32'd2);
    tick();
    in_valid = 1'b0;
    chk_wr("mov", 1'b1, 3'd5, 16'hBEEF);
    chk("mov_flags", {16'd0, current_flags}, 32'h0002);
    chk("mov_count", {16'd0, retired_count}, 32'd3);
    tick();

    // DIV r7: high word wraps to r0; single write when dual writes are off
    drive(1'b1, OP_DIV, 3'd7, 1'b1, 16'h0011, 16'h0003, 16'h0000);
    tick();
    in_valid = 1'b0;
    chk_wr("div_lo", 1'b1, 3'd7, 16'h0011);
    chk("div_lo_ready", {31'd0, in_ready}, 32'd0);
    chk("div2_we", {31'd0, rf_we2}, 32'd1);
    chk("div2_waddr", {29'd0, rf_waddr2}, 32'd7);
    chk("div2_ready", {31'd0, in_ready2}, 32'd1);
    tick();
    chk_wr("div_hi", 1'b1, 3'd0, 16'h0003);
    chk("div2_no_hi", {31'd0, rf_we2}, 32'd0);
    chk("div2_ready_after", {31'd0, in_ready2}, 32'd1);
    tick();

    // CMP: flags only
    drive(1'b1, OP_CMP, 3'd1, 1'b1, 16'h7777, 16'h0, 16'h000C);
    tick();
    in_valid = 1'b0;
    chk_wr("cmp", 1'b0, 3'd0, 16'h0);
    chk("cmp_flags", {16'd0, current_flags}, 32'h000C);
    chk("cmp_count", {16'd0, retired_count}, 32'd5);

    // LBH: writes rd, flags untouched
    drive(1'b1, OP_LBH, 3'd6, 1'b0, 16'hAB00, 16'h0, 16'hFFFF);
    tick();
    in_valid = 1'b0;
    chk_wr("lbh", 1'b1, 3'd6, 16'hAB00);
    chk("lbh_flags", {16'd0, current_flags}, 32'h000C);
    chk("lbh_count", {16'd0, retired_count}, 32'd6);
    tick();

    // Reset during the low write of a MUL, with in_valid still high
    drive(1'b1, OP_MUL, 3'd1, 1'b1, 16'h1111, 16'h2222, 16'h00F0);
    tick();
    chk_wr("rmul_lo", 1'b1, 3'd1, 16'h1111);
    chk("rmul_flags", {16'd0, current_flags}, 32'h00F0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    chk_wr("rmul_rst", 1'b0, 3'd0, 16'h0);
    chk("rmul_rst_waddr", {29'd0, rf_waddr}, 32'd0);
    chk("rmul_rst_wdata", {16'd0, rf_wdata}, 32'd0);
    chk("rmul_rst_flags", {16'd0, current_flags}, 32'd0);
    chk("rmul_rst_count", {16'd0, retired_count}, 32'd0);
    chk("rmul_rst_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk_wr("rmul_no_hi", 1'b0, 3'd0, 16'h0);

    // Counter wrap
    drive(1'b1, OP_ADD, 3'd1, 1'b1, 16'h0001, 16'h0, 16'h0);
    for (int i = 0; i < 65535; i++) tick();
    chk("wrap_pre", {16'd0, retired_count}, 32'h0000FFFF);
    tick();
    in_valid = 1'b0;
    chk("wrap_post", {16'd0, retired_count}, 32'h00000000);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_writeback_stage.md
Name: ex_writeback_stage

Overview:
- Pipeline stage directly downstream of the ALU.
- Registers the ALU outputs (result_0, result_1, next_flags, alu_en_out) and owns the architectural flag register, replacing the combinational Flag_Register.
- Sequences register-file writes through a single write port: single-result ops take one write cycle; MUL/DIV take two (low word, then high word/remainder).
- Drives a forwarding bus and a retired-instruction counter.

Parameters:
- DATA_W, 16, datapath and flag width
- REG_AW, 3, register-file address width (8 registers)
- DUAL_WRITE_EN, 1, 1 = write result_1 to rd+1 for MUL/DIV; 0 = discard result_1
- CNT_W, 16, retired-instruction counter width

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream has an ALU result this cycle
- in_ready  output  1  stage can accept this cycle (combinational)
- opcode  input  5  instruction opcode, encoded per parameters.v macros
- rd  input  REG_AW  destination register
- alu_en_out  input  1  ALU-class op (1) or move/load-byte op (0)
- result_0  input  DATA_W  primary result
- result_1  input  DATA_W  MUL high word / DIV remainder
- next_flags  input  DATA_W  flags computed by the ALU
- current_flags  output  DATA_W  architectural flag register, fed back to the ALU
- rf_we  output  1  register-file write enable
- rf_waddr  output  REG_AW  write address
- rf_wdata  output  DATA_W  write data
- fwd_valid  output  1  equals rf_we; forwarding bus valid
- fwd_rd  output  REG_AW  equals rf_waddr
- fwd_data  output  DATA_W  equals rf_wdata
- retired_count  output  CNT_W  accepted-instruction count

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it takes effect at the rising edge of clk while reset=1.
- Reset values: state=S_IDLE, current_flags=0, rf_we=0, rf_waddr=0, rf_wdata=0, retired_count=0, and all capture registers 0.
- Accept: an input is accepted when in_valid && in_ready at a rising edge. in_ready = !(state==S_WR0 && dual_q).
- writes_rd:
  - When alu_en_out=1: 1 unless opcode is `CMP, `SETF, `CLRF or `CPLF.
  - When alu_en_out=0: 1 only for `LBL, `LBH or `MOV.
- dual = DUAL_WRITE_EN && alu_en_out && (opcode is `MUL or `DIV).
- Flags: on accept with alu_en_out=1, current_flags <= next_flags at the same edge. The ALU therefore sees the new flags in the following cycle. On accept with alu_en_out=0, flags are unchanged.
- retired_count increments by 1 per accept and wraps from 2^CNT_W-1 to 0.
- States:
  - S_IDLE: rf_we=0.
  - S_WR0: rf_we=writes_rd_q, rf_waddr=rd_q, rf_wdata=res0_q.
  - S_WR1: rf_we=1, rf_waddr=(rd_q+1) mod 2^REG_AW (rd=7 writes to 0), rf_wdata=res1_q.
- Transitions:
  - Accept from any state -> S_WR0, capturing opcode-derived writes_rd/dual, rd, result_0 and result_1.
  - S_WR0 && dual_q -> S_WR1. No accept is possible in this case.
  - S_WR0 && !dual_q with no accept -> S_IDLE.
  - S_WR1 with no accept -> S_IDLE.
- Latency: accepted at edge N -> low write visible during cycle N+1 -> high write during N+2. Back-to-back single ops sustain 1/cycle; each MUL/DIV inserts exactly one in_ready=0 cycle.
- Outputs are driven from registered state only; there is no combinational path from inputs to the rf_*/fwd_* outputs.
- Ops that do not write (CMP, SETF, ...) still occupy S_WR0 for one cycle with rf_we=0 and are counted.
- in_valid while in_ready=0: nothing is captured, and upstream must hold its inputs.
- Reset mid-operation, including in S_WR0 with a pending high write: the pending write is abandoned, the stage goes to S_IDLE, and flags clear to 0.
- Reset has priority over a simultaneous accept.

Test Plan:
- Reset, then ADD accepted (rd=2, result_0=0x1234, next_flags=0x0081) -> next cycle rf_we=1, waddr=2, wdata=0x1234; current_flags=0x0081; retired_count=1.
- MUL (rd=3, result_0=0x5678, result_1=0x0009) followed immediately by a held MOV -> cycle1 write r3=0x5678 with in_ready=0; cycle2 write r4=0x0009 with MOV accepted; cycle3 MOV write.
- DIV with rd=7, result_1=0x0003 -> high write goes to r0; with DUAL_WRITE_EN=0 there is no second cycle and in_ready stays 1.
- CMP with next_flags=0x000C -> rf_we stays 0 and current_flags=0x000C; LBH (alu_en_out=0) writes rd and leaves flags unchanged.
- Reset asserted during the S_WR0 cycle of a MUL -> no r(rd+1) write ever occurs, and outputs return to reset values.
- Preload retired_count to 0xFFFF via 65535 accepts, then one more accept -> count wraps to 0x0000.
